mp4_sram_2p: RTL and testbench

Parametrised synchronous SRAM model with one read/write port (A) and one read-only port (B), sharing a single clock. It generalises the single-port cache data array in three ways:
- configurable width and depth;
- configurable byte-mask granularity;
- selectable read latency (1 or 2) with a per-port read-valid pipeline, and a defined read-during-write policy.

It backs cache data/tag arrays in which fill (A) and lookup (B) run concurrently.

---
 rtl/mp4_sram_2p_pkg.sv | 20 ++
 rtl/mp4_sram_2p_if.sv | 33 +++
 rtl/mp4_sram_2p_rd_pipe.sv | 52 +++++
 rtl/mp4_sram_2p.sv | 103 ++++++++++
 tb/tb_mp4_sram_2p.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mp4_sram_2p_pkg.sv
// sram_pkg: shared types and helpers for the mp4_sram_2p two-port SRAM model.
//   rdw_mode_e       : port-B read-during-write policy (old word / merged new word)
//   MAX_READ_LATENCY : largest supported read latency
//   lane_merge()     : bit-level masked merge; applied per bit so it is width-generic
package sram_pkg;

  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  localparam int unsigned MAX_READ_LATENCY = 2;

  // Returns new_bit where the covering lane is enabled, otherwise keeps old_bit.
  function automatic logic lane_merge(input logic old_bit, input logic new_bit,
                                      input logic mask_bit);
    return mask_bit ? new_bit : old_bit;
  endfunction

endpackage

// File: rtl/mp4_sram_2p_if.sv
// mp4_sram_2p_if: bus bundle for the two-port SRAM.
//   Port A (read/write): csb_a, web_a, wmask_a, addr_a, din_a -> dout_a, dout_a_valid
//   Port B (read only) : csb_b, addr_b                        -> dout_b, dout_b_valid
//   master modport drives requests; slave modport is the memory side.
interface mp4_sram_2p_if #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned WMASK_GRAN = 8
);
  localparam int unsigned NUM_WMASKS = DATA_WIDTH / WMASK_GRAN;

  logic                  csb_a;
  logic                  web_a;
  logic [NUM_WMASKS-1:0] wmask_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] din_a;
  logic [DATA_WIDTH-1:0] dout_a;
  logic                  dout_a_valid;
  logic                  csb_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] dout_b;
  logic                  dout_b_valid;

  modport master (
    output csb_a, web_a, wmask_a, addr_a, din_a, csb_b, addr_b,
    input  dout_a, dout_a_valid, dout_b, dout_b_valid
  );

  modport slave (
    input  csb_a, web_a, wmask_a, addr_a, din_a, csb_b, addr_b,
    output dout_a, dout_a_valid, dout_b, dout_b_valid
  );
endinterface

// File: rtl/mp4_sram_2p_rd_pipe.sv
// sram_rd_pipe: read-data/valid pipeline for one SRAM read port.
//   clk, rst   : clock, async active-high reset (clears every stage)
//   rd_en      : read accepted on this edge; rd_data is the word sampled on it
//   dout       : holds the last completed read
//   dout_valid : one-cycle pulse, READ_LATENCY edges after the sampling edge
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
);

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $fatal(1, "sram_rd_pipe: READ_LATENCY %0d is not 1 or 2", READ_LATENCY);
  end

  // Stage 0 captures the word on the sampling edge, so the array may be
  // overwritten on that same edge without disturbing an old-data read.
  logic [READ_LATENCY-1:0] r_vld;
  logic [DATA_WIDTH-1:0]   r_dat [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   r_dout;
  logic                    r_dout_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) r_dat[i] <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_vld[0] <= rd_en;
      if (rd_en) r_dat[0] <= rd_data;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
      end
      r_dout_valid <= r_vld[READ_LATENCY-1];
      if (r_vld[READ_LATENCY-1]) r_dout <= r_dat[READ_LATENCY-1];
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: rtl/mp4_sram_2p.sv
// mp4_sram_2p: synchronous SRAM, port A read/write with lane mask, port B read only.
//   clk, rst : shared clock, async active-high reset (clears read pipes, not contents)
//   sram     : mp4_sram_2p_if.slave bundle carrying both ports
// Optional: define SRAM_COLLISION_CHECK_EN to add a 16-bit saturating collision_cnt
// (same-address A write / B read on one edge) with a $warning per event.
module mp4_sram_2p
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned WMASK_GRAN   = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter rdw_mode_e   RDW_MODE     = RDW_OLD
) (
  input logic          clk,
  input logic          rst,
  mp4_sram_2p_if.slave sram
);

  localparam int unsigned NUM_WMASKS = DATA_WIDTH / WMASK_GRAN;
  localparam int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % WMASK_GRAN != 0) begin : g_bad_gran
    $fatal(1, "mp4_sram_2p: DATA_WIDTH %0d not a multiple of WMASK_GRAN %0d",
           DATA_WIDTH, WMASK_GRAN);
  end

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  logic                  w_we_a;
  logic                  w_re_a;
  logic                  w_re_b;
  logic                  w_same_addr;
  logic [DATA_WIDTH-1:0] w_old_a;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_rd_a;
  logic [DATA_WIDTH-1:0] w_rd_b;

  // Writes are gated by rst here; reads are gated so reset never launches a read.
  assign w_we_a      = !rst && !sram.csb_a && !sram.web_a;
  assign w_re_a      = !rst && !sram.csb_a && sram.web_a;
  assign w_re_b      = !rst && !sram.csb_b;
  assign w_same_addr = (sram.addr_a == sram.addr_b);

  always_comb begin
    w_old_a = r_mem[sram.addr_a];
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      w_merged[i] = lane_merge(w_old_a[i], sram.din_a[i], sram.wmask_a[i / int'(WMASK_GRAN)]);
    end
  end

  always_ff @(posedge clk) begin
    if (w_we_a) r_mem[sram.addr_a] <= w_merged;
  end

  assign w_rd_a = w_old_a;
  // New-data mode forwards the merged word; old-data mode relies on the pipe
  // capturing the array before the write lands.
  assign w_rd_b = (RDW_MODE == RDW_NEW && w_we_a && w_same_addr) ? w_merged
                                                                 : r_mem[sram.addr_b];

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_a (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (w_re_a),
    .rd_data   (w_rd_a),
    .dout      (sram.dout_a),
    .dout_valid(sram.dout_a_valid)
  );

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_b (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (w_re_b),
    .rd_data   (w_rd_b),
    .dout      (sram.dout_b),
    .dout_valid(sram.dout_b_valid)
  );

`ifdef SRAM_COLLISION_CHECK_EN
  logic [15:0] collision_cnt;
  logic        w_collision;

  assign w_collision = w_we_a && w_re_b && w_same_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collision_cnt <= '0;
    end else if (w_collision) begin
      if (collision_cnt != 16'hFFFF) collision_cnt <= collision_cnt + 16'd1;
      $warning("sram collision at %0t: addr %0d, RDW_MODE %0d", $time, sram.addr_a,
               RDW_MODE);
    end
  end
`endif

endmodule

// File: tb/tb_mp4_sram_2p.sv
// tb_mp4_sram_2p: directed bench for mp4_sram_2p.
//   dut1: READ_LATENCY 1, RDW old data; dut2: READ_LATENCY 2, RDW new data.
//   Both DUTs receive identical stimulus; each is checked against its own timing.
module tb_mp4_sram_2p;
  import sram_pkg::*;

  logic         clk;
  logic         rst;
  logic         csb_a;
  logic         web_a;
  logic [31:0]  wmask_a;
  logic [4:0]   addr_a;
  logic [255:0] din_a;
  logic         csb_b;
  logic [4:0]   addr_b;

  int n_checks;
  int n_fail;

  mp4_sram_2p_if #(.DATA_WIDTH(256), .ADDR_WIDTH(5), .WMASK_GRAN(8)) if1 ();
  mp4_sram_2p_if #(.DATA_WIDTH(256), .ADDR_WIDTH(5), .WMASK_GRAN(8)) if2 ();

  assign if1.csb_a   = csb_a;
  assign if1.web_a   = web_a;
  assign if1.wmask_a = wmask_a;
  assign if1.addr_a  = addr_a;
  assign if1.din_a   = din_a;
  assign if1.csb_b   = csb_b;
  assign if1.addr_b  = addr_b;
  assign if2.csb_a   = csb_a;
  assign if2.web_a   = web_a;
  assign if2.wmask_a = wmask_a;
  assign if2.addr_a  = addr_a;
  assign if2.din_a   = din_a;
  assign if2.csb_b   = csb_b;
  assign if2.addr_b  = addr_b;

  mp4_sram_2p #(
    .DATA_WIDTH(256), .ADDR_WIDTH(5), .WMASK_GRAN(8), .READ_LATENCY(1), .RDW_MODE(RDW_OLD)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .sram(if1)
  );

  mp4_sram_2p #(
    .DATA_WIDTH(256), .ADDR_WIDTH(5), .WMASK_GRAN(8), .READ_LATENCY(2), .RDW_MODE(RDW_NEW)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .sram(if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csb_a = 1'b1;
    web_a = 1'b1;
    csb_b = 1'b1;
  endtask

  task automatic a_write(input logic [4:0] a, input logic [255:0] d, input logic [31:0] m);
    csb_a   = 1'b0;
    web_a   = 1'b0;
    addr_a  = a;
    din_a   = d;
    wmask_a = m;
    tick();
    idle();
  endtask

  logic [255:0] bdat [3];
  logic [255:0] exp7;
  logic         exp1;
  logic         exp2;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bdat[0]  = {32{8'h10}};
    bdat[1]  = {32{8'h21}};
    bdat[2]  = {32{8'h32}};
    exp7     = {{31{8'h11}}, 8'hFF};
    rst      = 1'b1;
    idle();
    wmask_a  = '0;
    addr_a   = '0;
    addr_b   = '0;
    din_a    = '0;
    #2;
    check("rst_dout_a1", if1.dout_a, '0);
    check("rst_dout_b1", if1.dout_b, '0);
    check("rst_vld1", 256'({if1.dout_a_valid, if1.dout_b_valid}), '0);
    check("rst_dout_a2", if2.dout_a, '0);
    check("rst_dout_b2", if2.dout_b, '0);
    check("rst_vld2", 256'({if2.dout_a_valid, if2.dout_b_valid}), '0);
    tick();
    tick();
    rst = 1'b0;

    // Preload.
    a_write(5'd3, {32{8'hA5}}, 32'hFFFF_FFFF);
    check("wr_no_vld_a", 256'(if1.dout_a_valid), '0);
    check("wr_hold_a", if1.dout_a, '0);
    a_write(5'd0, bdat[0], 32'hFFFF_FFFF);
    a_write(5'd1, bdat[1], 32'hFFFF_FFFF);
    a_write(5'd2, bdat[2], 32'hFFFF_FFFF);
    a_write(5'd5, '0, 32'hFFFF_FFFF);
    a_write(5'd7, {32{8'h11}}, 32'hFFFF_FFFF);
    a_write(5'd7, {32{8'hFF}}, 32'h0000_0001);
    a_write(5'd7, {32{8'h77}}, 32'h0000_0000);

    // Port B read of addr 3: latency 1 on dut1, 2 on dut2.
    csb_b  = 1'b0;
    addr_b = 5'd3;
    tick();
    idle();
    check("b3_vld1_e0", 256'(if1.dout_b_valid), '0);
    tick();
    check("b3_vld1_e1", 256'(if1.dout_b_valid), 256'(1));
    check("b3_dat1_e1", if1.dout_b, {32{8'hA5}});
    check("b3_vld2_e1", 256'(if2.dout_b_valid), '0);
    tick();
    check("b3_vld1_e2", 256'(if1.dout_b_valid), '0);
    check("b3_hold1_e2", if1.dout_b, {32{8'hA5}});
    check("b3_vld2_e2", 256'(if2.dout_b_valid), 256'(1));
    check("b3_dat2_e2", if2.dout_b, {32{8'hA5}});
    tick();
    check("b3_vld2_e3", 256'(if2.dout_b_valid), '0);

    // Port A read of addr 7: only lane 0 updated, zero-mask write was a no-op.
    csb_a  = 1'b0;
    web_a  = 1'b1;
    addr_a = 5'd7;
    tick();
    idle();
    tick();
    check("a7_vld1", 256'(if1.dout_a_valid), 256'(1));
    check("a7_dat1", if1.dout_a, exp7);
    tick();
    check("a7_vld2", 256'(if2.dout_a_valid), 256'(1));
    check("a7_dat2", if2.dout_a, exp7);

    // Read-during-write on addr 5.
    csb_a   = 1'b0;
    web_a   = 1'b0;
    addr_a  = 5'd5;
    din_a   = {32{8'h5A}};
    wmask_a = 32'hFFFF_FFFF;
    csb_b   = 1'b0;
    addr_b  = 5'd5;
    tick();
    idle();
    tick();
    check("rdw_old_vld1", 256'(if1.dout_b_valid), 256'(1));
    check("rdw_old_dat1", if1.dout_b, '0);
    tick();
    check("rdw_new_vld2", 256'(if2.dout_b_valid), 256'(1));
    check("rdw_new_dat2", if2.dout_b, {32{8'h5A}});
`ifdef SRAM_COLLISION_CHECK_EN
    check("coll_cnt1", 256'(dut1.collision_cnt), 256'(1));
    check("coll_cnt2", 256'(dut2.collision_cnt), 256'(1));
`endif

    // Back-to-back B reads of addrs 0,1,2.
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        csb_b  = 1'b0;
        addr_b = 5'(i);
      end else begin
        csb_b = 1'b1;
      end
      tick();
      exp1 = (i >= 1 && i <= 3);
      exp2 = (i >= 2 && i <= 4);
      check($sformatf("b2b_vld1_%0d", i), 256'(if1.dout_b_valid), 256'(exp1));
      check($sformatf("b2b_vld2_%0d", i), 256'(if2.dout_b_valid), 256'(exp2));
      if (exp1) check($sformatf("b2b_dat1_%0d", i), if1.dout_b, bdat[i-1]);
      if (exp2) check($sformatf("b2b_dat2_%0d", i), if2.dout_b, bdat[i-2]);
    end

    // Reset mid-pipeline; a write attempted during reset must not commit.
    csb_b  = 1'b0;
    addr_b = 5'd3;
    tick();
    idle();
    rst = 1'b1;
    #1;
    check("midrst_vld2", 256'(if2.dout_b_valid), '0);
    check("midrst_dat2", if2.dout_b, '0);
    check("midrst_dat1", if1.dout_b, '0);
    csb_a   = 1'b0;
    web_a   = 1'b0;
    addr_a  = 5'd0;
    din_a   = {32{8'hEE}};
    wmask_a = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("inrst_vld_%0d", i),
            256'({if1.dout_b_valid, if2.dout_b_valid, if1.dout_a_valid, if2.dout_a_valid}), '0);
    end
    idle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("postrst_vld2_%0d", i), 256'(if2.dout_b_valid), '0);
      check($sformatf("postrst_dat2_%0d", i), if2.dout_b, '0);
    end

    // Deselected ports ignore everything.
    for (int i = 0; i < 10; i++) begin
      csb_a   = 1'b1;
      csb_b   = 1'b1;
      web_a   = 1'($urandom_range(0, 1));
      addr_a  = 5'($urandom_range(0, 31));
      addr_b  = 5'($urandom_range(0, 31));
      din_a   = {8{$urandom}};
      wmask_a = $urandom;
      tick();
      check($sformatf("csb_vld_%0d", i),
            256'({if1.dout_b_valid, if2.dout_b_valid, if1.dout_a_valid, if2.dout_a_valid}), '0);
    end

    // Contents survive reset and deselected toggling.
    idle();
    csb_b  = 1'b0;
    addr_b = 5'd0;
    csb_a  = 1'b0;
    web_a  = 1'b1;
    addr_a = 5'd2;
    tick();
    csb_a  = 1'b1;
    addr_b = 5'd3;
    tick();
    idle();
    check("keep_a2_vld1", 256'(if1.dout_a_valid), 256'(1));
    check("keep_a2_dat1", if1.dout_a, bdat[2]);
    check("keep_b0_dat1", if1.dout_b, bdat[0]);
    tick();
    check("keep_b0_vld2", 256'(if2.dout_b_valid), 256'(1));
    check("keep_b0_dat2", if2.dout_b, bdat[0]);
    check("keep_b3_dat1", if1.dout_b, {32{8'hA5}});
    tick();
    check("keep_b3_vld2", 256'(if2.dout_b_valid), 256'(1));
    check("keep_b3_dat2", if2.dout_b, {32{8'hA5}});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
